// File: rtl/universal_register_gen2.sv
`default_nettype none
// ============================================================================
// Module      : universal_register_gen2
// Description : Parametrised universal register for a shift-and-add datapath.
//               Single-cycle hold, shift left/right by one, increment,
//               decrement and parallel load, plus a multi-cycle burst shift
//               by a programmable amount with a busy/done handshake.
//               carry_out captures the last bit shifted out, the increment
//               carry or the decrement borrow.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH        register width in bits (>= 2)
//   SHAMT_W      width of the burst shift-amount port
// Ports
//   clk          in   rising-edge clock
//   clr          in   synchronous active-high reset
//   op_valid     in   command strobe, accepted when op_valid && !busy
//   mode         in   3-bit command code
//   shamt        in   burst shift count, sampled at acceptance
//   load_data    in   parallel load value
//   serial_in_l  in   bit entering q[0] on left shifts
//   serial_in_r  in   bit entering q[WIDTH-1] on right shifts
//   rotate       in   rotate select (effective only with UREG_ROTATE_EN)
//   q            out  register contents
//   serial_out_l out  q[WIDTH-1]
//   serial_out_r out  q[0]
//   carry_out    out  last bit out / inc carry / dec borrow
//   busy         out  high while a burst is in progress (SHIFT or DONE)
//   done         out  one-cycle pulse at burst completion
// Configuration macro
//   UREG_ROTATE_EN  when defined, rotate=1 turns all shifts into rotates
// ============================================================================
module universal_register_gen2 #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               op_valid,
  input  logic [2:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               serial_in_l,
  input  logic               serial_in_r,
  input  logic               rotate,
  output logic [WIDTH-1:0]   q,
  output logic               serial_out_l,
  output logic               serial_out_r,
  output logic               carry_out,
  output logic               busy,
  output logic               done
);

  localparam logic [2:0] c_MODE_HOLD = 3'b000;
  localparam logic [2:0] c_MODE_SHL1 = 3'b001;
  localparam logic [2:0] c_MODE_SHR1 = 3'b010;
  localparam logic [2:0] c_MODE_INC  = 3'b011;
  localparam logic [2:0] c_MODE_DEC  = 3'b100;
  localparam logic [2:0] c_MODE_LOAD = 3'b101;
  localparam logic [2:0] c_MODE_BSHL = 3'b110;
  localparam logic [2:0] c_MODE_BSHR = 3'b111;

  localparam logic [WIDTH-1:0]   c_Q_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SHAMT_W-1:0] c_CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_q;
  logic               r_carry;
  logic [SHAMT_W-1:0] r_count;
  logic               r_dir_right;   // latched burst direction

  logic w_rot;
  logic w_shl_in;
  logic w_shr_in;

`ifdef UREG_ROTATE_EN
  assign w_rot = rotate;
`else
  // rotate is kept on the port list for interface compatibility only
  logic w_unused_rotate;
  assign w_unused_rotate = rotate;
  assign w_rot           = 1'b0;
`endif

  // Bit entering the vacated end: the opposite end when rotating
  assign w_shl_in = w_rot ? r_q[WIDTH-1] : serial_in_l;
  assign w_shr_in = w_rot ? r_q[0]       : serial_in_r;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= ST_IDLE;
      r_q         <= '0;
      r_carry     <= 1'b0;
      r_count     <= '0;
      r_dir_right <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (op_valid) begin
            case (mode)
              c_MODE_HOLD: ;
              c_MODE_SHL1: begin
                r_q     <= {r_q[WIDTH-2:0], w_shl_in};
                r_carry <= r_q[WIDTH-1];
              end
              c_MODE_SHR1: begin
                r_q     <= {w_shr_in, r_q[WIDTH-1:1]};
                r_carry <= r_q[0];
              end
              c_MODE_INC: begin
                r_q     <= r_q + c_Q_ONE;
                r_carry <= &r_q;
              end
              c_MODE_DEC: begin
                r_q     <= r_q - c_Q_ONE;
                r_carry <= ~|r_q;
              end
              c_MODE_LOAD: begin
                r_q     <= load_data;
                r_carry <= 1'b0;
              end
              c_MODE_BSHL, c_MODE_BSHR: begin
                r_count     <= shamt;
                r_dir_right <= (mode == c_MODE_BSHR);
                r_state     <= ST_SHIFT;
              end
              default: ;
            endcase
          end
        end
        ST_SHIFT: begin
          // The count==0 cycle performs no shift, so shamt=k gives k shifts
          if (r_count != '0) begin
            if (r_dir_right) begin
              r_q     <= {w_shr_in, r_q[WIDTH-1:1]};
              r_carry <= r_q[0];
            end else begin
              r_q     <= {r_q[WIDTH-2:0], w_shl_in};
              r_carry <= r_q[WIDTH-1];
            end
            r_count <= r_count - c_CNT_ONE;
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign q            = r_q;
  assign carry_out    = r_carry;
  assign serial_out_l = r_q[WIDTH-1];
  assign serial_out_r = r_q[0];
  assign busy         = (r_state != ST_IDLE);
  assign done         = (r_state == ST_DONE);

endmodule
`default_nettype wire
